// File: rtl/thunderbird_lamp_monitor.sv
// thunderbird_lamp_monitor: samples the six tail lamps on each tick, tracks the sequence,
// flags the first illegal step and counts completed left/right runs.
module thunderbird_lamp_monitor #(
    parameter int CNT_W      = 8,
    parameter bit CHECK_HOLD = 1'b1
) (
    input  logic             Clk,
    input  logic             Rs,
    input  logic             Tick,
    input  logic             LA,
    input  logic             LB,
    input  logic             LC,
    input  logic             RA,
    input  logic             RB,
    input  logic             RC,
    input  logic             FaultClr,
    output logic [1:0]       Dir,
    output logic [1:0]       Phase,
    output logic             Fault,
    output logic [1:0]       FaultCode,
    output logic [CNT_W-1:0] LeftCnt,
    output logic [CNT_W-1:0] RightCnt
);
    // bit 2 selects the right side, bits 1:0 are the lit-lamp count; 100 is hazard
    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_L1   = 3'b001;
    localparam logic [2:0] S_L2   = 3'b010;
    localparam logic [2:0] S_L3   = 3'b011;
    localparam logic [2:0] S_HZ   = 3'b100;
    localparam logic [2:0] S_R1   = 3'b101;
    localparam logic [2:0] S_R2   = 3'b110;
    localparam logic [2:0] S_R3   = 3'b111;

    logic [5:0]       pat;
    logic [2:0]       obs;
    logic             legal, hold, step_ok, new_fault, left_inc, right_inc;
    logic [1:0]       new_code;
    logic [2:0]       state_d, state_q;
    logic [1:0]       dir_d, dir_q, phase_d, phase_q, code_d, code_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] left_d, left_q, right_d, right_q;

    assign pat = {LC, LB, LA, RA, RB, RC};

    always_comb begin
        obs = pat == 6'b001000 ? S_L1 :
              pat == 6'b011000 ? S_L2 :
              pat == 6'b111000 ? S_L3 :
              pat == 6'b000100 ? S_R1 :
              pat == 6'b000110 ? S_R2 :
              pat == 6'b000111 ? S_R3 :
              pat == 6'b111111 ? S_HZ : S_IDLE;
        legal     = pat == 6'b000000 || obs != S_IDLE;
        hold      = obs != S_IDLE && obs == state_q;
        step_ok   = obs == S_IDLE ||
                    (state_q == S_IDLE && (obs == S_L1 || obs == S_R1 || obs == S_HZ)) ||
                    (state_q[1:0] != 2'd0 && state_q[1:0] != 2'd3 &&
                     obs == {state_q[2], state_q[1:0] + 2'd1});
        new_fault = Tick && (!legal || (hold ? CHECK_HOLD : !step_ok));
        new_code  = !legal ? 2'b01 : hold ? 2'b11 : 2'b10;
        state_d   = !Tick ? state_q : !legal ? S_IDLE : hold ? state_q : obs;
        left_inc  = Tick && legal && state_q == S_L3 && obs == S_IDLE;
        right_inc = Tick && legal && state_q == S_R3 && obs == S_IDLE;
        left_d    = left_inc && !(&left_q) ? left_q + CNT_W'(1) : left_q;
        right_d   = right_inc && !(&right_q) ? right_q + CNT_W'(1) : right_q;
        dir_d     = state_d == S_HZ ? 2'b11 : state_d[2] ? 2'b10 : state_d != S_IDLE ? 2'b01 : 2'b00;
        phase_d   = state_d == S_HZ ? 2'd3 : state_d[1:0];
        // a fault arriving together with a clear survives the clear
        fault_d   = new_fault || (fault_q && !FaultClr);
        code_d    = new_fault && (!fault_q || FaultClr) ? new_code : FaultClr ? 2'b00 : code_q;
    end

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            state_q <= S_IDLE;
            dir_q   <= 2'b00;
            phase_q <= 2'd0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign Dir       = dir_q;
    assign Phase     = phase_q;
    assign Fault     = fault_q;
    assign FaultCode = code_q;
    assign LeftCnt   = left_q;
    assign RightCnt  = right_q;
endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
// tb_thunderbird_lamp_monitor: drives both hold-check variants with directed and random
// lamp traffic and compares against a side/lamp-count reference model.
module tb_thunderbird_lamp_monitor;
    logic       Clk = 1'b0, Rs = 1'b0, Tick = 1'b0, FaultClr = 1'b0;
    logic [5:0] pat = 6'b0;
    logic [1:0] dir [2], phase [2], code [2];
    logic       flt [2];
    logic [7:0] lcnt [2], rcnt [2];
    int         errors = 0, checks = 0;
    int         m_s [2], m_n [2], m_f [2], m_c [2], m_l [2], m_r [2];

    always #5 Clk = ~Clk;

    thunderbird_lamp_monitor #(.CNT_W(8), .CHECK_HOLD(1'b0)) u_h0 (
        .Clk(Clk), .Rs(Rs), .Tick(Tick),
        .LA(pat[3]), .LB(pat[4]), .LC(pat[5]), .RA(pat[2]), .RB(pat[1]), .RC(pat[0]),
        .FaultClr(FaultClr), .Dir(dir[0]), .Phase(phase[0]), .Fault(flt[0]),
        .FaultCode(code[0]), .LeftCnt(lcnt[0]), .RightCnt(rcnt[0]));

    thunderbird_lamp_monitor #(.CNT_W(8), .CHECK_HOLD(1'b1)) u_h1 (
        .Clk(Clk), .Rs(Rs), .Tick(Tick),
        .LA(pat[3]), .LB(pat[4]), .LC(pat[5]), .RA(pat[2]), .RB(pat[1]), .RC(pat[0]),
        .FaultClr(FaultClr), .Dir(dir[1]), .Phase(phase[1]), .Fault(flt[1]),
        .FaultCode(code[1]), .LeftCnt(lcnt[1]), .RightCnt(rcnt[1]));

    // side: 0 off, 1 left, 2 right, 3 hazard; n = lamps lit per side
    function automatic void classify(input logic [5:0] p, output int side, output int n, output bit ok);
        int ln, rn;
        bit vl, vr;
        logic [2:0] l, r;
        l  = p[5:3];
        r  = p[2:0];
        ln = $countones(l);
        rn = $countones(r);
        vl = (l == 3'b000 || l == 3'b001 || l == 3'b011 || l == 3'b111);
        vr = (r == 3'b000 || r == 3'b100 || r == 3'b110 || r == 3'b111);
        ok = 1'b1; side = 0; n = 0;
        if (!vl || !vr) ok = 1'b0;
        else if (ln == 0 && rn == 0) begin side = 0; n = 0; end
        else if (ln == 3 && rn == 3) begin side = 3; n = 3; end
        else if (rn == 0) begin side = 1; n = ln; end
        else if (ln == 0) begin side = 2; n = rn; end
        else ok = 1'b0;
    endfunction

    function automatic logic [5:0] mkpat(input int side, input int n);
        logic [2:0] lv [4];
        logic [2:0] rv [4];
        lv = '{3'b000, 3'b001, 3'b011, 3'b111};
        rv = '{3'b000, 3'b100, 3'b110, 3'b111};
        if (side == 3) return 6'b111111;
        if (side == 1) return {lv[n], 3'b000};
        if (side == 2) return {3'b000, rv[n]};
        return 6'b000000;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_s[h] = 0; m_n[h] = 0; m_f[h] = 0; m_c[h] = 0; m_l[h] = 0; m_r[h] = 0;
        end
    endtask

    task automatic model_step(input bit tk, input logic [5:0] p, input bit clr);
        int os, on, nc;
        bit ok, nf;
        for (int h = 0; h < 2; h++) begin
            nf = 1'b0; nc = 0;
            if (tk) begin
                classify(p, os, on, ok);
                if (!ok) begin
                    nf = 1'b1; nc = 1; m_s[h] = 0; m_n[h] = 0;
                end else if (os != 0 && os == m_s[h] && on == m_n[h]) begin
                    if (h == 1) begin nf = 1'b1; nc = 3; end
                end else if (os == 0 || (m_s[h] == 0 && (os == 3 || on == 1)) ||
                             ((m_s[h] == 1 || m_s[h] == 2) && os == m_s[h] && on == m_n[h] + 1)) begin
                    if (os == 0 && m_n[h] == 3 && m_s[h] == 1 && m_l[h] < 255) m_l[h]++;
                    if (os == 0 && m_n[h] == 3 && m_s[h] == 2 && m_r[h] < 255) m_r[h]++;
                    m_s[h] = os; m_n[h] = on;
                end else begin
                    nf = 1'b1; nc = 2; m_s[h] = os; m_n[h] = on;
                end
            end
            if (clr) begin
                m_f[h] = nf ? 1 : 0;
                m_c[h] = nf ? nc : 0;
            end else if (nf) begin
                if (m_f[h] == 0) m_c[h] = nc;
                m_f[h] = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int h, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[hold=%0d] observed=%0d expected=%0d at %0t", tag, h, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int h = 0; h < 2; h++) begin
            chk("dir", h, 8'(dir[h]), 8'(m_s[h]));
            chk("phase", h, 8'(phase[h]), 8'(m_n[h]));
            chk("fault", h, 8'(flt[h]), 8'(m_f[h]));
            chk("code", h, 8'(code[h]), 8'(m_c[h]));
            chk("lcnt", h, lcnt[h], 8'(m_l[h]));
            chk("rcnt", h, rcnt[h], 8'(m_r[h]));
        end
    endtask

    task automatic step(input bit tk, input logic [5:0] p, input bit clr);
        Tick = tk; pat = p; FaultClr = clr;
        @(posedge Clk);
        model_step(tk, p, clr);
        #1;
        check_all();
    endtask

    localparam logic [5:0] OFF = 6'b000000, L1 = 6'b001000, L2 = 6'b011000, L3 = 6'b111000;
    localparam logic [5:0] R1 = 6'b000100, R2 = 6'b000110, R3 = 6'b000111, HZ = 6'b111111;

    initial begin
        model_reset();
        #1 check_all();
        #6 Rs = 1'b1;
        step(1, OFF, 0); step(1, L1, 0); step(1, L2, 0); step(1, L3, 0); step(1, OFF, 0);
        step(1, OFF, 0); step(1, R1, 0); step(1, R2, 0); step(1, OFF, 0);
        for (int i = 0; i < 258; i++) begin
            step(1, R1, 0); step(1, R2, 0); step(1, R3, 0); step(1, OFF, 0);
        end
        step(1, HZ, 0); step(1, OFF, 0);
        step(1, 6'b010000, 0); step(1, L1, 0); step(1, L3, 0);
        step(0, OFF, 1); step(1, L1, 0); step(1, L3, 0); step(1, OFF, 0);
        step(0, OFF, 1); step(1, L1, 0); step(1, L1, 0); step(1, L2, 0);
        step(0, HZ, 0); step(0, 6'b101010, 0); step(1, L3, 0); step(1, OFF, 0);
        step(0, OFF, 1); step(1, L1, 0); step(1, L2, 0);
        #2 Rs = 1'b0;
        #1 model_reset();
        check_all();
        #2 Rs = 1'b1;
        step(1, L2, 0);
        step(1, 6'b000010, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] p;
            int s, n;
            s = m_s[1]; n = m_n[1];
            if ($urandom_range(0, 9) < 7) begin
                if ((s == 1 || s == 2) && n < 3 && $urandom_range(0, 3) != 0) p = mkpat(s, n + 1);
                else if (s != 0) p = OFF;
                else p = mkpat($urandom_range(0, 3), 1);
            end else begin
                p = 6'($urandom);
            end
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 19) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
